multi_operand_add_ctrl: RTL
===========================

MULTI_OPERAND_ADD_CTRL -- requirements
Module: multi_operand_add_ctrl

Interface
REQ-001 SHALL have parameter: MAX_OPS, 15, maximum operands per job (1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  job request; sampled only in IDLE.
REQ-005 SHALL have port: num_ops  input  4  operand count for the job; sampled with start.
REQ-006 SHALL have port: in_valid  input  1  operand valid from source.
REQ-007 SHALL have port: in_data  input  20  unsigned operand.
REQ-008 SHALL have port: in_ready  output  1  block accepts operand this cycle.
REQ-009 SHALL have port: busy  output  1  high in ACCUM and DONE states.
REQ-010 SHALL have port: done  output  1  one-cycle pulse; result and overflow valid.
REQ-011 SHALL have port: result  output  20  accumulated sum modulo 2^20.
REQ-012 SHALL have port: overflow  output  1  sticky; set if any addition in the job produced a carry-out.
REQ-013 SHALL have port: ops_left  output  4  operands still expected in the current job.

Function
REQ-014 SHALL instantiate exactly one carry_look_ahead_20_bit as the only adder; a = accumulator, b = in_data, cin = 0.
REQ-015 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-016 IDLE: in_ready=0, busy=0; on start=1 with num_ops>0 SHALL clear accumulator and overflow, load ops_left = min(num_ops, MAX_OPS), and go to ACCUM.
REQ-017 IDLE with start=1 and num_ops=0 SHALL clear accumulator and overflow and go directly to DONE (result=0, overflow=0).
REQ-018 ACCUM: in_ready SHALL be 1; a handshake is in_valid & in_ready in the same cycle.
REQ-019 On each handshake: accumulator <= adder sum; overflow <= overflow | adder cout; ops_left decrements by 1.
REQ-020 When the handshake accepts the operand with ops_left=1, SHALL go to DONE on the next edge.
REQ-021 in_valid=0 in ACCUM SHALL hold all state; there is no timeout.
REQ-022 DONE SHALL last exactly one cycle with done=1, in_ready=0, then return to IDLE.
REQ-023 Latency: done SHALL assert in the cycle after the last handshake.
REQ-024 result SHALL always equal the accumulator register; after DONE it SHALL hold until the next accepted start.
REQ-025 start in ACCUM or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-026 in_valid outside ACCUM SHALL be ignored; in_data SHALL NOT be added.
REQ-027 num_ops > MAX_OPS SHALL be clamped to MAX_OPS.
REQ-028 The accumulator SHALL wrap modulo 2^20 on carry-out; the carry SHALL be recorded only in overflow.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE with result=0, overflow=0, ops_left=0, done=0, busy=0, in_ready=0, regardless of clk.
REQ-030 Reset asserted mid-job SHALL abandon the job; no done pulse SHALL follow.
REQ-031 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled in IDLE.

Verification
REQ-032 Run start with num_ops=3, then operands 0x00001, 0x00002, 0x00003 back-to-back -> done pulses 1 cycle after the third handshake; result=0x00006, overflow=0.
REQ-033 Run num_ops=2 with operands 0xFFFFF and 0x00002 -> result=0x00001, overflow=1; overflow clears on the next start.
REQ-034 Run num_ops=2, with in_valid low for 5 cycles between operands 0x12345 and 0x00010 -> ops_left holds at 1 during the gap; result=0x12355.
REQ-035 Pulse start with num_ops=0 -> done is high in the next cycle, result=0, in_ready never asserts.
REQ-036 Pulse start again mid-job and drive in_valid in IDLE -> job unaffected and idle operand ignored; num_ops=15 with MAX_OPS=4 -> exactly 4 handshakes.
REQ-037 Assert rst_n=0 mid-job after 2 of 4 operands -> all outputs are 0 asynchronously and no done pulse occurs; a subsequent fresh job computes correctly.

Source files
------------

// File: rtl/multi_operand_add_ctrl.sv
// Multi-operand accumulator: sums a job of up to MAX_OPS unsigned 20-bit
// operands through a single carry-lookahead adder, wrapping modulo 2^20
// and recording any carry-out in a sticky overflow flag.

// 20-bit carry-lookahead adder built from five 4-bit lookahead groups,
// with the group carries rippling from one group to the next.
module carry_look_ahead_20_bit (
    input  logic [19:0] a,
    input  logic [19:0] b,
    input  logic        cin,
    output logic [19:0] sum,
    output logic        cout
);

    logic [19:0] g;
    logic [19:0] p;
    logic [20:0] c;

    // Generate/propagate terms and per-group lookahead carry equations
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int blk = 0; blk < 5; blk++) begin
            c[4*blk+1] = g[4*blk] | (p[4*blk] & c[4*blk]);
            c[4*blk+2] = g[4*blk+1] | (p[4*blk+1] & g[4*blk])
                       | (p[4*blk+1] & p[4*blk] & c[4*blk]);
            c[4*blk+3] = g[4*blk+2] | (p[4*blk+2] & g[4*blk+1])
                       | (p[4*blk+2] & p[4*blk+1] & g[4*blk])
                       | (p[4*blk+2] & p[4*blk+1] & p[4*blk] & c[4*blk]);
            c[4*blk+4] = g[4*blk+3] | (p[4*blk+3] & g[4*blk+2])
                       | (p[4*blk+3] & p[4*blk+2] & g[4*blk+1])
                       | (p[4*blk+3] & p[4*blk+2] & p[4*blk+1] & g[4*blk])
                       | (p[4*blk+3] & p[4*blk+2] & p[4*blk+1] & p[4*blk] & c[4*blk]);
        end
        sum  = p ^ c[19:0];
        cout = c[20];
    end

endmodule

module multi_operand_add_ctrl #(
    parameter int MAX_OPS = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  num_ops,
    input  logic        in_valid,
    input  logic [19:0] in_data,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic [19:0] result,
    output logic        overflow,
    output logic [3:0]  ops_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] MAX_OPS_L = 4'(MAX_OPS);

    state_t      state_q, state_d;
    logic [19:0] acc_q, acc_d;
    logic        ovf_q, ovf_d;
    logic [3:0]  ops_q, ops_d;
    logic [19:0] add_sum;
    logic        add_cout;
    logic        handshake;
    logic [3:0]  ops_clamped;

    // The only adder in the block: accumulator plus the incoming operand
    carry_look_ahead_20_bit u_cla (
        .a    (acc_q),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign handshake   = in_valid & in_ready;
    assign ops_clamped = (num_ops > MAX_OPS_L) ? MAX_OPS_L : num_ops;

    // State, accumulator, overflow and operand counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            ops_q   <= ops_d;
        end
    end

    // Next-state logic: start only matters in IDLE, operands only in ACCUM
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        ops_d   = ops_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (num_ops == 4'd0) begin
                        ops_d   = '0;
                        state_d = DONE;
                    end else begin
                        ops_d   = ops_clamped;
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (handshake) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_cout;
                    ops_d = ops_q - 4'd1;
                    if (ops_q == 4'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == ACCUM);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign result   = acc_q;
    assign overflow = ovf_q;
    assign ops_left = ops_q;

endmodule
